// File: rtl/sram_track_mixer.sv
// sram_track_mixer: walks two recorded tracks in SRAM, averages them sample
// by sample (signed, floor) and writes the result to the destination track.
// Eight cycles per sample; the SRAM bus is owned only while oBusy is high.
//
// Handshake: iStart is a one-cycle request accepted only in IDLE; oBusy is
// high from the cycle after acceptance until the DONE state exits; oDone is a
// one-cycle completion pulse and never follows an abort or reset. iAbort
// returns to IDLE at the next edge from any state and beats a same-cycle
// iStart.
module sram_track_mixer #(
    parameter int TRACK_LEN = 128000,
    parameter int BASE_A    = 0,
    parameter int BASE_B    = 128000,
    parameter int BASE_DST  = 0
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic        iAbort,
    output logic        oBusy,
    output logic        oDone,
    output logic [17:0] oSample_cnt,
    output logic [17:0] oSRAM_ADDR,
    output logic [15:0] oSRAM_DQ_OUT,
    output logic        oSRAM_DQ_OE,
    input  logic [15:0] iSRAM_DQ,
    output logic        oSRAM_WE_N,
    output logic        oSRAM_OE_N
);

    typedef enum logic [3:0] {
        IDLE,
        RD_A,
        RD_A_LAT,
        RD_B,
        RD_B_LAT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        NEXT,
        DONE
    } state_t;

    localparam logic [17:0] LAST_IDX   = 18'(TRACK_LEN - 1);
    localparam logic [17:0] BASE_A_W   = 18'(BASE_A);
    localparam logic [17:0] BASE_B_W   = 18'(BASE_B);
    localparam logic [17:0] BASE_DST_W = 18'(BASE_DST);

    state_t      state_q, state_d;
    logic [17:0] idx_q, idx_d;
    logic [15:0] sample_a_q, sample_a_d;
    logic [15:0] sample_b_q, sample_b_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic [16:0] sum_ab;
    logic [15:0] mix;

    // Next state, then the registered bus outputs belonging to that next state
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sample_a_d = sample_a_q;
        sample_b_d = sample_b_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        dq_out_d   = dq_out_q;
        dq_oe_d    = dq_oe_q;
        we_n_d     = 1'b1;
        oe_n_d     = oe_n_q;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d = RD_A;
                    idx_d   = '0;
                end
            end
            RD_A:     state_d = RD_A_LAT;
            RD_A_LAT: begin
                sample_a_d = iSRAM_DQ;
                state_d    = RD_B;
            end
            RD_B:     state_d = RD_B_LAT;
            RD_B_LAT: begin
                sample_b_d = iSRAM_DQ;
                state_d    = WR_SETUP;
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD:  state_d = NEXT;
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 18'd1;
                    state_d = RD_A;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Abort beats everything, including a start seen in IDLE
        if (iAbort) begin
            state_d = IDLE;
            idx_d   = idx_q;
            done_d  = 1'b0;
        end

        // Sign-extend to 17 bits; the arithmetic shift floors toward -inf
        sum_ab = {sample_a_q[15], sample_a_q} + {sample_b_d[15], sample_b_d};
        mix    = 16'(sum_ab >> 1);

        case (state_d)
            RD_A, RD_A_LAT: begin
                addr_d  = BASE_A_W + idx_d;
                oe_n_d  = 1'b0;
                dq_oe_d = 1'b0;
            end
            RD_B, RD_B_LAT: begin
                addr_d  = BASE_B_W + idx_d;
                oe_n_d  = 1'b0;
                dq_oe_d = 1'b0;
            end
            WR_SETUP: begin
                addr_d   = BASE_DST_W + idx_d;
                dq_out_d = mix;
                oe_n_d   = 1'b1;
                dq_oe_d  = 1'b1;
            end
            WR_PULSE: we_n_d = 1'b0;
            WR_HOLD:  we_n_d = 1'b1;
            default: begin
                oe_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            sample_a_q <= '0;
            sample_b_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sample_a_q <= sample_a_d;
            sample_b_q <= sample_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
        end
    end

    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oSample_cnt  = idx_q;
    assign oSRAM_ADDR   = addr_q;
    assign oSRAM_DQ_OUT = dq_out_q;
    assign oSRAM_DQ_OE  = dq_oe_q;
    assign oSRAM_WE_N   = we_n_q;
    assign oSRAM_OE_N   = oe_n_q;

endmodule
